// File: rtl/key_overlay_scheduler_if.sv
// Bundle between the sync generator / key pads and the overlay scheduler.
// The master side drives vsync and the raw keys; the slave side returns highlight state.
interface key_overlay_scheduler_if;
    logic        iVS;
    logic [6:0]  key_in;
    logic [6:0]  oKEY_MASK;
    logic [2:0]  oACTIVE_KEY;
    logic        oFRAME_TICK;
    logic [15:0] oFRAME_CNT;

    modport master (
        output iVS,
        output key_in,
        input  oKEY_MASK,
        input  oACTIVE_KEY,
        input  oFRAME_TICK,
        input  oFRAME_CNT
    );

    modport slave (
        input  iVS,
        input  key_in,
        output oKEY_MASK,
        output oACTIVE_KEY,
        output oFRAME_TICK,
        output oFRAME_CNT
    );
endinterface

// File: rtl/key_overlay_scheduler.sv
// Frame-synchronous key highlight scheduler: per-key hold/decay FSMs advanced once per vsync,
// so the overlay mask only ever changes at frame boundaries.
module key_overlay_scheduler #(
    parameter int unsigned HOLD_FRAMES = 4
) (
    input logic                    iVGA_CLK,
    input logic                    iRST_n,
    key_overlay_scheduler_if.slave ovl
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLit   = 2'd1,
        StDecay = 2'd2
    } key_state_e;

    localparam logic [3:0] DecayInit = (HOLD_FRAMES >= 2) ? 4'(HOLD_FRAMES - 2) : 4'd0;

    logic [6:0]  key_meta;
    logic [6:0]  key_s;
    logic [6:0]  pending;
    logic [6:0]  pending_d;
    logic [6:0]  sample;
    logic        vs_prev;
    logic        tick;
    key_state_e  state_q [7];
    key_state_e  state_d [7];
    logic [3:0]  cnt_q [7];
    logic [3:0]  cnt_d [7];
    logic [6:0]  mask_q;
    logic [6:0]  mask_d;
    logic [2:0]  active_q;
    logic [2:0]  active_d;
    logic        frame_tick_q;
    logic [15:0] frame_cnt_q;

    // Lowest set bit wins (C first); 7 means nothing lit.
    function automatic logic [2:0] lowest_set(input logic [6:0] m);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign tick = vs_prev & ~ovl.iVS;

    always_comb begin
        sample    = pending | key_s;
        // A key still held at the tick carries into the next frame.
        pending_d = tick ? key_s : (pending | key_s);
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = '0;
        for (int i = 0; i < 7; i++) begin
            if (tick) begin
                case (state_q[i])
                    StIdle: begin
                        if (sample[i]) state_d[i] = StLit;
                    end
                    StLit: begin
                        if (!sample[i]) begin
                            if (HOLD_FRAMES <= 1) begin
                                state_d[i] = StIdle;
                            end else begin
                                state_d[i] = StDecay;
                                cnt_d[i]   = DecayInit;
                            end
                        end
                    end
                    StDecay: begin
                        if (sample[i]) begin
                            state_d[i] = StLit;
                        end else if (cnt_q[i] == 4'd0) begin
                            state_d[i] = StIdle;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 4'd1;
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
            mask_d[i] = (state_d[i] != StIdle);
        end
        active_d = lowest_set(mask_d);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_meta     <= '0;
            key_s        <= '0;
            pending      <= '0;
            vs_prev      <= 1'b0;
            mask_q       <= '0;
            active_q     <= 3'd7;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
            for (int i = 0; i < 7; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            key_meta     <= ovl.key_in;
            key_s        <= key_meta;
            pending      <= pending_d;
            vs_prev      <= ovl.iVS;
            mask_q       <= mask_d;
            active_q     <= active_d;
            frame_tick_q <= tick;
            if (tick) frame_cnt_q <= frame_cnt_q + 16'd1;
            for (int i = 0; i < 7; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign ovl.oKEY_MASK   = mask_q;
    assign ovl.oACTIVE_KEY = active_q;
    assign ovl.oFRAME_TICK = frame_tick_q;
    assign ovl.oFRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_key_overlay_scheduler.sv
// Bench for key_overlay_scheduler: HOLD_FRAMES=4 and HOLD_FRAMES=1 instances share stimulus;
// expected per-frame mask/priority values are queued and compared at each frame tick.
module tb_key_overlay_scheduler;

    logic       clk;
    logic       rst_n;
    logic       vs;
    logic [6:0] keys;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] mask;
        logic [2:0] act;
    } exp_t;

    exp_t sb[$];

    key_overlay_scheduler_if bus4();
    key_overlay_scheduler_if bus1();

    assign bus4.iVS    = vs;
    assign bus4.key_in = keys;
    assign bus1.iVS    = vs;
    assign bus1.key_in = keys;

    key_overlay_scheduler #(.HOLD_FRAMES(4)) dut4 (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .ovl      (bus4)
    );

    key_overlay_scheduler #(.HOLD_FRAMES(1)) dut1 (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .ovl      (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input logic vs_level);
        rst_n = 1'b0;
        keys  = '0;
        vs    = vs_level;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One frame: vsync high 8 cycles (hold keys throughout, pulse keys for one cycle),
    // then vsync low until the frame tick appears; samples the post-tick outputs.
    task automatic do_frame(input logic [6:0] hold, input logic [6:0] pulse,
                            output logic [6:0] m4, output logic [2:0] a4,
                            output logic [6:0] m1, output logic [2:0] a1,
                            output bit ok, output bit stable);
        logic [6:0] start_m;
        m4 = '0; a4 = '0; m1 = '0; a1 = '0;
        ok = 1'b0;
        stable = 1'b1;
        keys = hold;
        vs = 1'b1;
        start_m = bus4.oKEY_MASK;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            keys = hold | ((c == 3) ? pulse : 7'd0);
            if (bus4.oKEY_MASK !== start_m || bus4.oFRAME_TICK !== 1'b0) stable = 1'b0;
        end
        keys = hold;
        vs = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin
            @(negedge clk);
            if (bus4.oFRAME_TICK === 1'b1) begin
                ok = 1'b1;
                m4 = bus4.oKEY_MASK;
                a4 = bus4.oACTIVE_KEY;
                m1 = bus1.oKEY_MASK;
                a1 = bus1.oACTIVE_KEY;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++;
        if (bus4.oKEY_MASK !== 7'd0) begin
            errors++;
            $display("FAIL reset_mask4: got %b, expected 0000000", bus4.oKEY_MASK);
        end
        checks++;
        if (bus4.oACTIVE_KEY !== 3'd7) begin
            errors++;
            $display("FAIL reset_active4: got %0d, expected 7", bus4.oACTIVE_KEY);
        end
        checks++;
        if (bus4.oFRAME_TICK !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b, expected 0", bus4.oFRAME_TICK);
        end
        checks++;
        if (bus4.oFRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h, expected 0000", bus4.oFRAME_CNT);
        end
        checks++;
        if (bus1.oKEY_MASK !== 7'd0 || bus1.oACTIVE_KEY !== 3'd7) begin
            errors++;
            $display("FAIL reset_dut1: got mask %b act %0d, expected 0000000 / 7",
                     bus1.oKEY_MASK, bus1.oACTIVE_KEY);
        end
    endtask

    task automatic test_single_press();
        logic [6:0] m4, m1;
        logic [2:0] a4, a1;
        bit ok, stable, all_stable;
        exp_t e;
        apply_reset(1'b1);
        all_stable = 1'b1;
        repeat (4) sb.push_back('{mask: 7'b0000100, act: 3'd2});
        sb.push_back('{mask: 7'b0000000, act: 3'd7});
        for (int f = 0; f < 5; f++) begin
            do_frame(7'd0, (f == 0) ? 7'b0000100 : 7'd0, m4, a4, m1, a1, ok, stable);
            all_stable &= stable;
            e = sb.pop_front();
            checks++;
            if (!ok || m4 !== e.mask || a4 !== e.act) begin
                errors++;
                $display("FAIL single_press frame %0d: mask %b act %0d tick %0b, expected %b / %0d",
                         f, m4, a4, ok, e.mask, e.act);
            end
        end
        checks++;
        if (!all_stable) begin
            errors++;
            $display("FAIL mid_frame_change: mask or tick moved outside a tick, expected none");
        end
    endtask

    task automatic test_held_key();
        logic [6:0] m4, m1;
        logic [2:0] a4, a1;
        bit ok, stable;
        exp_t e;
        apply_reset(1'b1);
        repeat (6) sb.push_back('{mask: 7'b0000001, act: 3'd0});
        sb.push_back('{mask: 7'b0000000, act: 3'd7});
        for (int f = 0; f < 7; f++) begin
            do_frame((f < 2) ? 7'b0000001 : 7'd0, 7'd0, m4, a4, m1, a1, ok, stable);
            e = sb.pop_front();
            checks++;
            if (!ok || m4 !== e.mask || a4 !== e.act) begin
                errors++;
                $display("FAIL held_key frame %0d: mask %b act %0d tick %0b, expected %b / %0d",
                         f, m4, a4, ok, e.mask, e.act);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] m4, m1;
        logic [2:0] a4, a1;
        logic [6:0] p;
        bit ok, stable;
        exp_t e;
        apply_reset(1'b1);
        repeat (4) sb.push_back('{mask: 7'b1001000, act: 3'd3});
        repeat (2) sb.push_back('{mask: 7'b1000000, act: 3'd6});
        sb.push_back('{mask: 7'b0000000, act: 3'd7});
        for (int f = 0; f < 7; f++) begin
            p = (f == 0) ? 7'b1001000 : ((f == 2) ? 7'b1000000 : 7'd0);
            do_frame(7'd0, p, m4, a4, m1, a1, ok, stable);
            e = sb.pop_front();
            checks++;
            if (!ok || m4 !== e.mask || a4 !== e.act) begin
                errors++;
                $display("FAIL simultaneous frame %0d: mask %b act %0d tick %0b, expected %b / %0d",
                         f, m4, a4, ok, e.mask, e.act);
            end
        end
    endtask

    task automatic test_repress();
        logic [6:0] m4, m1;
        logic [2:0] a4, a1;
        bit ok, stable;
        exp_t e;
        apply_reset(1'b1);
        repeat (7) sb.push_back('{mask: 7'b0000001, act: 3'd0});
        sb.push_back('{mask: 7'b0000000, act: 3'd7});
        for (int f = 0; f < 8; f++) begin
            do_frame(7'd0, (f == 0 || f == 3) ? 7'b0000001 : 7'd0, m4, a4, m1, a1, ok, stable);
            e = sb.pop_front();
            checks++;
            if (!ok || m4 !== e.mask || a4 !== e.act) begin
                errors++;
                $display("FAIL repress frame %0d: mask %b act %0d tick %0b, expected %b / %0d",
                         f, m4, a4, ok, e.mask, e.act);
            end
        end
    endtask

    task automatic test_hold_one_and_reset();
        logic [6:0] m4, m1;
        logic [2:0] a4, a1;
        bit ok, stable;
        exp_t e;
        apply_reset(1'b1);
        sb.push_back('{mask: 7'b0000001, act: 3'd0});
        sb.push_back('{mask: 7'b0000000, act: 3'd7});
        sb.push_back('{mask: 7'b0000010, act: 3'd1});
        for (int f = 0; f < 3; f++) begin
            do_frame(7'd0, (f == 0) ? 7'b0000001 : ((f == 2) ? 7'b0000010 : 7'd0),
                     m4, a4, m1, a1, ok, stable);
            e = sb.pop_front();
            checks++;
            if (!ok || m1 !== e.mask || a1 !== e.act) begin
                errors++;
                $display("FAIL hold_one frame %0d: mask %b act %0d tick %0b, expected %b / %0d",
                         f, m1, a1, ok, e.mask, e.act);
            end
        end
        // Mid-frame, mid-hold on both instances: reset must act without a clock edge.
        vs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.oKEY_MASK !== 7'd0 || bus4.oACTIVE_KEY !== 3'd7 || bus4.oFRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL async_reset4: mask %b act %0d cnt %h, expected 0000000 / 7 / 0000",
                     bus4.oKEY_MASK, bus4.oACTIVE_KEY, bus4.oFRAME_CNT);
        end
        checks++;
        if (bus1.oKEY_MASK !== 7'd0 || bus1.oACTIVE_KEY !== 3'd7) begin
            errors++;
            $display("FAIL async_reset1: mask %b act %0d, expected 0000000 / 7",
                     bus1.oKEY_MASK, bus1.oACTIVE_KEY);
        end
        keys = 7'h7F;
        repeat (3) @(negedge clk);
        keys = 7'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_frame(7'd0, 7'd0, m4, a4, m1, a1, ok, stable);
        checks++;
        if (!ok || m4 !== 7'd0 || m1 !== 7'd0 || a4 !== 3'd7) begin
            errors++;
            $display("FAIL press_in_reset: mask4 %b mask1 %b act %0d tick %0b, expected 0/0/7/1",
                     m4, m1, a4, ok);
        end
    endtask

    task automatic test_frame_tick();
        logic [6:0] m4, m1;
        logic [2:0] a4, a1;
        bit ok, stable;
        int ticks;
        apply_reset(1'b0);
        ticks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus4.oFRAME_TICK === 1'b1) ticks++;
        end
        checks++;
        if (ticks !== 0 || bus4.oFRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL tick_at_release: %0d ticks cnt %h, expected 0 ticks cnt 0000",
                     ticks, bus4.oFRAME_CNT);
        end
        vs = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        ticks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus4.oFRAME_TICK === 1'b1) ticks++;
        end
        checks++;
        if (ticks !== 1) begin
            errors++;
            $display("FAIL single_tick: %0d tick cycles, expected 1", ticks);
        end
        checks++;
        if (bus4.oFRAME_CNT !== 16'd1) begin
            errors++;
            $display("FAIL first_count: cnt %h, expected 0001", bus4.oFRAME_CNT);
        end
        @(negedge clk);
        force dut4.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut4.frame_cnt_q;
        do_frame(7'd0, 7'd0, m4, a4, m1, a1, ok, stable);
        checks++;
        if (!ok || bus4.oFRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL count_wrap: cnt %h tick %0b, expected 0000 with tick",
                     bus4.oFRAME_CNT, ok);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vs    = 1'b1;
        keys  = '0;
        test_reset();
        test_single_press();
        test_held_key();
        test_simultaneous();
        test_repress();
        test_hold_one_and_reset();
        test_frame_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
